// File: rtl/stopwatch_core.sv
// stopwatch_core: edge-detected clear/pause controls, PAUSED/RUNNING/ADJUST state machine, BCD MM:SS count.
// Optional lap hold (select_in edges while running) is built when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter int unsigned TICKS_PER_SEC = 32'd100000000,
  parameter int unsigned ADJ_TICKS     = 32'd50000000,
  parameter int unsigned BLINK_TICKS   = 32'd25000000
) (
  input  logic       clk,
  input  logic       reset2,
  input  logic       rst_in,
  input  logic       pause_in,
  input  logic       adj_in,
  input  logic       select_in,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blink
);

  localparam int PW = (TICKS_PER_SEC > 32'd1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = (ADJ_TICKS > 32'd1) ? $clog2(ADJ_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 32'd1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 32'd1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(32'd1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(32'd0);
  localparam logic [AW-1:0] ADJ_MAX    = AW'(ADJ_TICKS - 32'd1);
  localparam logic [AW-1:0] ADJ_ONE    = AW'(32'd1);
  localparam logic [AW-1:0] ADJ_ZERO   = AW'(32'd0);
  localparam logic [BW-1:0] BLK_MAX    = BW'(BLINK_TICKS - 32'd1);
  localparam logic [BW-1:0] BLK_ONE    = BW'(32'd1);
  localparam logic [BW-1:0] BLK_ZERO   = BW'(32'd0);

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_RUNNING = 2'd1,
    ST_ADJUST  = 2'd2
  } state_t;

  // Increment a tens/ones pair modulo 60; returns {carry, tens, ones} and never leaves BCD range.
  function automatic logic [8:0] inc_mod60(input logic [3:0] tens, input logic [3:0] ones);
    if (ones >= 4'd9) begin
      if (tens >= 4'd5) inc_mod60 = {1'b1, 4'd0, 4'd0};
      else              inc_mod60 = {1'b0, tens + 4'd1, 4'd0};
    end else begin
      inc_mod60 = {1'b0, tens, ones + 4'd1};
    end
  endfunction

  state_t          state_r, state_nxt_s;
  logic            rst_prev_r, pause_prev_r, arm_r;
  logic            rst_edge_s, pause_edge_s;
  logic [PW-1:0]   presc_r, presc_nxt_s;
  logic [AW-1:0]   adj_cnt_r, adj_cnt_nxt_s;
  logic [BW-1:0]   blink_cnt_r, blink_cnt_nxt_s;
  logic            blink_r, blink_nxt_s;
  logic            running_r;
  logic [15:0]     cnt_r, cnt_nxt_s;
  logic [8:0]      sec_inc_s, min_inc_s;
  logic            enter_adj_s, count_en_s, adj_en_s;
  logic            sec_tick_s, adj_tick_s, blink_tog_s;

  // arm_r masks edges on the first cycle after reset so inputs held high through reset are not acted on.
  assign rst_edge_s   = rst_in & ~rst_prev_r & arm_r;
  assign pause_edge_s = pause_in & ~pause_prev_r & arm_r;
  assign sec_inc_s    = inc_mod60(cnt_r[7:4], cnt_r[3:0]);
  assign min_inc_s    = inc_mod60(cnt_r[15:12], cnt_r[11:8]);

  // Next state: adjust switch first, then clear, then pause toggle.
  always_comb begin
    state_nxt_s = state_r;
    if (adj_in && (state_r != ST_ADJUST)) begin
      state_nxt_s = ST_ADJUST;
    end else if (!adj_in && (state_r == ST_ADJUST)) begin
      state_nxt_s = ST_PAUSED;
    end else if (rst_edge_s) begin
      state_nxt_s = (state_r == ST_RUNNING) ? ST_PAUSED : state_r;
    end else if (pause_edge_s && (state_r == ST_PAUSED)) begin
      state_nxt_s = ST_RUNNING;
    end else if (pause_edge_s && (state_r == ST_RUNNING)) begin
      state_nxt_s = ST_PAUSED;
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign enter_adj_s = (state_r != ST_ADJUST) && (state_nxt_s == ST_ADJUST);
  assign count_en_s  = (state_r == ST_RUNNING) && (state_nxt_s == ST_RUNNING);
  assign adj_en_s    = (state_r == ST_ADJUST) && (state_nxt_s == ST_ADJUST);
  assign sec_tick_s  = count_en_s && (presc_r == PRESC_MAX);
  assign adj_tick_s  = adj_en_s && (adj_cnt_r == ADJ_MAX);
  assign blink_tog_s = adj_en_s && (blink_cnt_r == BLK_MAX);

  // Prescalers, blink and digit next values.
  always_comb begin
    presc_nxt_s     = presc_r;
    adj_cnt_nxt_s   = adj_cnt_r;
    blink_cnt_nxt_s = blink_cnt_r;
    blink_nxt_s     = blink_r;
    cnt_nxt_s       = cnt_r;

    if (rst_edge_s || enter_adj_s) presc_nxt_s = PRESC_ZERO;
    else if (sec_tick_s)           presc_nxt_s = PRESC_ZERO;
    else if (count_en_s)           presc_nxt_s = presc_r + PRESC_ONE;
    else                           presc_nxt_s = presc_r;

    if (adj_en_s) begin
      adj_cnt_nxt_s   = adj_tick_s ? ADJ_ZERO : (adj_cnt_r + ADJ_ONE);
      blink_cnt_nxt_s = blink_tog_s ? BLK_ZERO : (blink_cnt_r + BLK_ONE);
      blink_nxt_s     = blink_tog_s ? ~blink_r : blink_r;
    end else begin
      adj_cnt_nxt_s   = ADJ_ZERO;
      blink_cnt_nxt_s = BLK_ZERO;
      blink_nxt_s     = 1'b0;
    end

    // Adjust ticks never carry between the minute and second fields.
    if (rst_edge_s) begin
      cnt_nxt_s = 16'h0000;
    end else if (sec_tick_s) begin
      if (sec_inc_s[8]) cnt_nxt_s = {min_inc_s[7:0], sec_inc_s[7:0]};
      else              cnt_nxt_s = {cnt_r[15:8], sec_inc_s[7:0]};
    end else if (adj_tick_s) begin
      if (select_in) cnt_nxt_s = {cnt_r[15:8], sec_inc_s[7:0]};
      else           cnt_nxt_s = {min_inc_s[7:0], cnt_r[7:0]};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State machine and all timekeeping registers.
  always_ff @(posedge clk) begin
    if (reset2) begin
      state_r      <= ST_PAUSED;
      rst_prev_r   <= 1'b0;
      pause_prev_r <= 1'b0;
      arm_r        <= 1'b0;
      presc_r      <= PRESC_ZERO;
      adj_cnt_r    <= ADJ_ZERO;
      blink_cnt_r  <= BLK_ZERO;
      blink_r      <= 1'b0;
      running_r    <= 1'b0;
      cnt_r        <= 16'h0000;
    end else begin
      state_r      <= state_nxt_s;
      rst_prev_r   <= rst_in;
      pause_prev_r <= pause_in;
      arm_r        <= 1'b1;
      presc_r      <= presc_nxt_s;
      adj_cnt_r    <= adj_cnt_nxt_s;
      blink_cnt_r  <= blink_cnt_nxt_s;
      blink_r      <= blink_nxt_s;
      running_r    <= (state_nxt_s == ST_RUNNING);
      cnt_r        <= cnt_nxt_s;
    end
  end

  assign running = running_r;
  assign blink   = blink_r;

`ifdef STOPWATCH_LAP_EN
  logic        sel_prev_r, sel_edge_s, hold_r, hold_nxt_s;
  logic [15:0] disp_r, disp_nxt_s;

  assign sel_edge_s = select_in & ~sel_prev_r & arm_r;

  // Lap hold freezes the displayed value while the live count keeps running.
  always_comb begin
    hold_nxt_s = hold_r;
    if (rst_edge_s || enter_adj_s)                   hold_nxt_s = 1'b0;
    else if (sel_edge_s && (state_r == ST_RUNNING))  hold_nxt_s = ~hold_r;
    else                                             hold_nxt_s = hold_r;
    if (hold_nxt_s) disp_nxt_s = disp_r;
    else            disp_nxt_s = cnt_nxt_s;
  end

  // Lap hold registers.
  always_ff @(posedge clk) begin
    if (reset2) begin
      sel_prev_r <= 1'b0;
      hold_r     <= 1'b0;
      disp_r     <= 16'h0000;
    end else begin
      sel_prev_r <= select_in;
      hold_r     <= hold_nxt_s;
      disp_r     <= disp_nxt_s;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = disp_r;
`else
  assign {min_tens, min_ones, sec_tens, sec_ones} = cnt_r;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed testbench for stopwatch_core with TICKS_PER_SEC=4, ADJ_TICKS=2, BLINK_TICKS=3.
module tb_stopwatch_core;
  logic clk = 1'b0;
  logic reset2, rst_in, pause_in, adj_in, select_in;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, blink;
  logic [15:0] digits;
  int checks = 0;
  int failures = 0;

  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  stopwatch_core #(.TICKS_PER_SEC(32'd4), .ADJ_TICKS(32'd2), .BLINK_TICKS(32'd3)) dut (
    .clk(clk), .reset2(reset2), .rst_in(rst_in), .pause_in(pause_in),
    .adj_in(adj_in), .select_in(select_in),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_pause();
    pause_in = 1'b1; step(1); pause_in = 1'b0;
  endtask

  // Load MM:SS through adjust mode, then return to PAUSED with select low.
  task automatic preset(input int mm, input int ss);
    rst_in = 1'b1; step(1); rst_in = 1'b0;
    adj_in = 1'b1; select_in = 1'b0; step(1);
    step(2 * mm);
    select_in = 1'b1; step(2 * ss);
    adj_in = 1'b0; select_in = 1'b0; step(1);
  endtask

  task automatic test_reset();
    reset2 = 1'b1; rst_in = 1'b1; pause_in = 1'b1; adj_in = 1'b0; select_in = 1'b0;
    step(2);
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=%h", digits, 16'h0000); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=%b", running, 1'b0); end
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL reset_blink got=%b exp=%b", blink, 1'b0); end
    reset2 = 1'b0;
    step(6);
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL post_reset_no_edge got=%b exp=%b", running, 1'b0); end
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL post_reset_digits got=%h exp=%h", digits, 16'h0000); end
    rst_in = 1'b0; pause_in = 1'b0; step(1);
  endtask

  task automatic test_run_pause();
    pulse_pause();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL run_start got=%b exp=%b", running, 1'b1); end
    step(3);
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL run_first_tick_early got=%h exp=%h", digits, 16'h0000); end
    step(1);
    checks++; if (digits !== 16'h0001) begin failures++; $display("FAIL run_first_tick got=%h exp=%h", digits, 16'h0001); end
    step(240);
    checks++; if (digits !== 16'h0101) begin failures++; $display("FAIL run_count got=%h exp=%h", digits, 16'h0101); end
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL run_running got=%b exp=%b", running, 1'b1); end
    pulse_pause();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_running got=%b exp=%b", running, 1'b0); end
    step(20);
    checks++; if (digits !== 16'h0101) begin failures++; $display("FAIL pause_frozen got=%h exp=%h", digits, 16'h0101); end
  endtask

  task automatic test_wrap();
    preset(59, 58);
    checks++; if (digits !== 16'h5958) begin failures++; $display("FAIL wrap_preset got=%h exp=%h", digits, 16'h5958); end
    pulse_pause();
    step(4);
    checks++; if (digits !== 16'h5959) begin failures++; $display("FAIL wrap_5959 got=%h exp=%h", digits, 16'h5959); end
    step(3);
    checks++; if (digits !== 16'h5959) begin failures++; $display("FAIL wrap_hold got=%h exp=%h", digits, 16'h5959); end
    step(1);
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL wrap_0000 got=%h exp=%h", digits, 16'h0000); end
    pulse_pause();
  endtask

  task automatic test_adjust();
    preset(7, 58);
    checks++; if (digits !== 16'h0758) begin failures++; $display("FAIL adj_preset got=%h exp=%h", digits, 16'h0758); end
    adj_in = 1'b1; select_in = 1'b1; step(1);
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL adj_blink_c0 got=%b exp=%b", blink, 1'b0); end
    pause_in = 1'b1; step(1);
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL adj_blink_c1 got=%b exp=%b", blink, 1'b0); end
    pause_in = 1'b0; step(1);
    checks++; if (digits !== 16'h0759) begin failures++; $display("FAIL adj_c2 got=%h exp=%h", digits, 16'h0759); end
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL adj_blink_c2 got=%b exp=%b", blink, 1'b0); end
    step(1);
    checks++; if (blink !== 1'b1) begin failures++; $display("FAIL adj_blink_c3 got=%b exp=%b", blink, 1'b1); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL adj_running got=%b exp=%b", running, 1'b0); end
    pause_in = 1'b1; step(1);
    checks++; if (digits !== 16'h0700) begin failures++; $display("FAIL adj_sec_wrap got=%h exp=%h", digits, 16'h0700); end
    pause_in = 1'b0; step(1);
    checks++; if (blink !== 1'b1) begin failures++; $display("FAIL adj_blink_c5 got=%b exp=%b", blink, 1'b1); end
    step(1);
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL adj_blink_c6 got=%b exp=%b", blink, 1'b0); end
    checks++; if (digits !== 16'h0701) begin failures++; $display("FAIL adj_c6 got=%h exp=%h", digits, 16'h0701); end
    adj_in = 1'b0; select_in = 1'b0; step(1);
    step(8);
    checks++; if (digits !== 16'h0701) begin failures++; $display("FAIL adj_exit_digits got=%h exp=%h", digits, 16'h0701); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL adj_exit_running got=%b exp=%b", running, 1'b0); end
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL adj_exit_blink got=%b exp=%b", blink, 1'b0); end
  endtask

  task automatic test_simultaneous();
    preset(0, 0);
    pulse_pause();
    step(28);
    checks++; if (digits !== 16'h0007) begin failures++; $display("FAIL sim_pre got=%h exp=%h", digits, 16'h0007); end
    rst_in = 1'b1; pause_in = 1'b1; step(1);
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL sim_clear got=%h exp=%h", digits, 16'h0000); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL sim_running got=%b exp=%b", running, 1'b0); end
    rst_in = 1'b0; pause_in = 1'b0; step(8);
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL sim_paused got=%h exp=%h", digits, 16'h0000); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    preset(0, 0);
    pulse_pause();
    step(12);
    checks++; if (digits !== 16'h0003) begin failures++; $display("FAIL lap_pre got=%h exp=%h", digits, 16'h0003); end
    select_in = 1'b1; step(1); select_in = 1'b0;
    step(8);
    checks++; if (digits !== 16'h0003) begin failures++; $display("FAIL lap_hold got=%h exp=%h", digits, 16'h0003); end
    select_in = 1'b1; step(1); select_in = 1'b0;
    checks++; if (digits !== 16'h0005) begin failures++; $display("FAIL lap_release got=%h exp=%h", digits, 16'h0005); end
    pulse_pause();
  endtask
`endif

  initial begin
    test_reset();
    test_run_pause();
    test_wrap();
    test_adjust();
    test_simultaneous();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
